// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared state encoding and width constants for norm_divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_N     = 32;
    localparam int DIV_CNT_W = $clog2(DIV_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/msb_onehot.sv
`default_nettype none
// ============================================================================
// Module      : msb_onehot
// Description : Isolates the most significant set bit of a vector (one-hot).
// Revision    : 1.0 - initial release
// ============================================================================
module msb_onehot #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_vec,
    output logic [N-1:0] o_onehot
);

    // w_any_above[i] is set when any bit strictly above i is set
    logic [N-1:0] w_any_above;

    assign w_any_above[N-1] = 1'b0;
    assign o_onehot[N-1]    = i_vec[N-1];

    generate
        for (genvar gi = N - 2; gi >= 0; gi--) begin : g_bit
            assign w_any_above[gi] = w_any_above[gi+1] | i_vec[gi+1];
            assign o_onehot[gi]    = i_vec[gi] & ~w_any_above[gi];
        end
    endgenerate

endmodule : msb_onehot
`default_nettype wire

// File: rtl/onehot_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : onehot_to_bin
// Description : One-hot to binary index encoder (all-zero input encodes 0).
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_to_bin #(
    parameter int N = 32,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_onehot,
    output logic [W-1:0] o_bin
);

    always_comb begin
        o_bin = '0;
        for (int i = 0; i < N; i++) begin
            if (i_onehot[i]) begin
                o_bin = o_bin | W'(i);
            end
        end
    end

endmodule : onehot_to_bin
`default_nettype wire

// File: rtl/norm_divider.sv
`default_nettype none
// ============================================================================
// Module      : norm_divider
// Description : Multi-cycle unsigned divider; operands are MSB-aligned in one
//               cycle so only the significant quotient bits are iterated.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_divider
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CNT_W = $clog2(N);

    div_state_t       r_state;
    div_state_t       w_state_nxt;

    logic [N-1:0]     r_rem;
    logic [N-1:0]     r_dsr;
    logic [N-1:0]     r_quot;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dbz;

    logic [N-1:0]     w_oh_dvd;
    logic [N-1:0]     w_oh_dsr;
    logic [CNT_W-1:0] w_pos_dvd;
    logic [CNT_W-1:0] w_pos_dsr;
    logic [CNT_W-1:0] w_shift;
    logic             w_accept;
    logic             w_dsr_zero;
    logic             w_trivial;
    logic             w_ge;

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

    assign w_accept   = in_valid & in_ready;
    assign w_dsr_zero = (r_dsr == '0);
    // Trivial operands are resolved in NORM from the captured registers
    assign w_trivial  = w_dsr_zero | (r_rem < r_dsr);
    assign w_ge       = (r_rem >= r_dsr);
    assign w_shift    = w_pos_dvd - w_pos_dsr;

    msb_onehot #(.N(N)) u_msb_dvd (
        .i_vec    (r_rem),
        .o_onehot (w_oh_dvd)
    );

    msb_onehot #(.N(N)) u_msb_dsr (
        .i_vec    (r_dsr),
        .o_onehot (w_oh_dsr)
    );

    onehot_to_bin #(.N(N), .W(CNT_W)) u_enc_dvd (
        .i_onehot (w_oh_dvd),
        .o_bin    (w_pos_dvd)
    );

    onehot_to_bin #(.N(N), .W(CNT_W)) u_enc_dsr (
        .i_onehot (w_oh_dsr),
        .o_bin    (w_pos_dsr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = NORM;
            NORM: w_state_nxt = w_trivial ? DONE : ITER;
            ITER: if (r_cnt == '0) w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_dsr  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rem  <= dividend;
                        r_dsr  <= divisor;
                        r_quot <= '0;
                        r_dbz  <= 1'b0;
                    end
                end
                NORM: begin
                    if (w_dsr_zero) begin
                        r_quot <= '1;
                        r_dbz  <= 1'b1;
                    end else if (!w_trivial) begin
                        // Align divisor MSB with dividend MSB; never overflows
                        r_dsr <= r_dsr << w_shift;
                        r_cnt <= w_shift;
                    end
                end
                ITER: begin
                    if (w_ge) begin
                        r_rem  <= r_rem - r_dsr;
                        r_quot <= {r_quot[N-2:0], 1'b1};
                    end else begin
                        r_quot <= {r_quot[N-2:0], 1'b0};
                    end
                    r_dsr <= r_dsr >> 1;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : norm_divider
`default_nettype wire

// File: tb/tb_norm_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_norm_divider
// Description : Directed, table-driven self-checking bench for norm_divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_norm_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    norm_divider #(.N(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_op(input string name, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk({name, "_in_ready_before"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0;
        chk({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        chk({name, "_in_ready_in_done"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_in_ready_after_hs"}, 32'(in_ready), 32'd1);
        chk({name, "_out_valid_after_hs"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        start_op(v.name, v.a, v.b);
        wait_done(lat);
        chk({v.name, "_latency"}, 32'(lat), 32'(v.lat));
        chk({v.name, "_quotient"}, quotient, v.q);
        chk({v.name, "_remainder"}, remainder, v.r);
        chk({v.name, "_dbz"}, 32'(div_by_zero), 32'(v.z));
        handshake(v.name);
    endtask

    initial begin
        vec_t v;
        int   lat;

        // name, dividend, divisor, quotient, remainder, dbz, edges to out_valid
        vecs[0] = '{"d100_7",    32'd100,         32'd7,  32'd14,         32'd2,    1'b0, 6};
        vecs[1] = '{"d5_0",      32'd5,           32'd0,  32'hFFFF_FFFF,  32'd5,    1'b1, 1};
        vecs[2] = '{"d3_10",     32'd3,           32'd10, 32'd0,          32'd3,    1'b0, 1};
        vecs[3] = '{"d0_9",      32'd0,           32'd9,  32'd0,          32'd0,    1'b0, 1};
        vecs[4] = '{"dmax_1",    32'hFFFF_FFFF,   32'd1,  32'hFFFF_FFFF,  32'd0,    1'b0, 33};
        vecs[5] = '{"d77_77",    32'd77,          32'd77, 32'd1,          32'd0,    1'b0, 2};
        vecs[6] = '{"d1000_33",  32'd1000,        32'd33, 32'd30,         32'd10,   1'b0, 6};
        vecs[7] = '{"d2p31_3",   32'h8000_0000,   32'd3,  32'd715827882,  32'd2,    1'b0, 32};
        vecs[8] = '{"d12_4",     32'd12,          32'd4,  32'd3,          32'd0,    1'b0, 3};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),    32'd1);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_quotient",  quotient,         32'd0);
        chk("rst_remainder", remainder,        32'd0);
        chk("rst_dbz",       32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // Result held stable while the consumer stalls
        start_op("hold", 32'd1000, 32'd33);
        wait_done(lat);
        chk("hold_latency", 32'(lat), 32'd6);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready",  32'(in_ready),  32'd0);
            chk("hold_quotient",  quotient,       32'd30);
            chk("hold_remainder", remainder,      32'd10);
        end
        handshake("hold");

        // Back-to-back: the second operation must be accepted right after the first handshake
        v = '{"b2b_a", 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 6};
        run_vec(v);
        v = '{"b2b_b", 32'd77, 32'd77, 32'd1, 32'd0, 1'b0, 2};
        run_vec(v);
        @(posedge clk);
        #1;
        chk("b2b_no_dup_out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of the iteration phase
        start_op("abort", 32'hFFFF_FFFF, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready",  32'(in_ready),    32'd1);
        chk("abort_out_valid", 32'(out_valid),   32'd0);
        chk("abort_quotient",  quotient,         32'd0);
        chk("abort_remainder", remainder,        32'd0);
        chk("abort_dbz",       32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) chk("abort_spurious_result", 32'(out_valid), 32'd0);
        end
        v = '{"after_abort", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 6};
        run_vec(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_norm_divider
`default_nettype wire
